// File: rtl/wb_pkg.sv
// Shared definitions for the write-back sequencer: source codes, state encoding, request payload.
package wb_pkg;

   localparam int unsigned SRC_W   = 3;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned NUM_SRC = 8;

   // Write-back mux source codes
   localparam logic [SRC_W-1:0] SRC_227   = 3'b000;
   localparam logic [SRC_W-1:0] SRC_LOAD  = 3'b001;
   localparam logic [SRC_W-1:0] SRC_ALU   = 3'b010;
   localparam logic [SRC_W-1:0] SRC_SHL   = 3'b011;
   localparam logic [SRC_W-1:0] SRC_HI    = 3'b100;
   localparam logic [SRC_W-1:0] SRC_LO    = 3'b101;
   localparam logic [SRC_W-1:0] SRC_SHREG = 3'b110;
   localparam logic [SRC_W-1:0] SRC_LT    = 3'b111;

   // Sources produced by multicycle units: load and shift register
   localparam logic [NUM_SRC-1:0] WAIT_MASK_DEFAULT = 8'b0100_0010;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      WAIT  = 2'b01,
      WRITE = 2'b10
   } wb_state_t;

   // Latched write-back request: mux select and destination register
   typedef struct packed {
      logic [SRC_W-1:0]  src;
      logic [ADDR_W-1:0] dst;
   } wb_req_t;

   // True when the source must be launched and awaited
   function automatic logic needs_unit(input logic [NUM_SRC-1:0] mask,
                                       input logic [SRC_W-1:0]   src);
      return mask[src];
   endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Watchdog counter: clear has priority over enable; flags the last allowed cycle.
module wb_timeout_cnt #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Count WAIT cycles since the unit was launched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign tc_c = (count == LAST);

endmodule

// File: rtl/wb_sequencer.sv
// Write-back sequencer: drives the write-back mux select and register write strobe,
// launching and awaiting multicycle producers under a watchdog.
module wb_sequencer
   import wb_pkg::*;
#(
   parameter int unsigned        TIMEOUT_CYCLES = 64,
   parameter logic [NUM_SRC-1:0] WAIT_MASK      = WAIT_MASK_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_req,
   input  logic [SRC_W-1:0]  wb_src,
   input  logic [ADDR_W-1:0] wb_dst,
   output logic              wb_ack,
   output logic              unit_start,
   input  logic              unit_done,
   input  logic              err_clr,
   output logic [SRC_W-1:0]  data_ctrl,
   output logic              reg_write,
   output logic [ADDR_W-1:0] reg_addr,
   output logic              busy,
   output logic              timeout_err
);

   wb_state_t state_q, state_d;
   wb_req_t   req_q, req_d;
   logic      start_d, write_d, busy_d, err_d;
   logic      cnt_clr, cnt_en, cnt_tc_c;

   wb_timeout_cnt #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .tc_c  (cnt_tc_c)
   );

   // State, latched request and decoded strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_q       <= '{src: SRC_ALU, dst: '0};
         unit_start  <= 1'b0;
         reg_write   <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         unit_start  <= start_d;
         reg_write   <= write_d;
         busy        <= busy_d;
         timeout_err <= err_d;
      end
   end

   // Next state, acceptance and next values of registered strobes
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      wb_ack  = 1'b0;
      start_d = 1'b0;
      write_d = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      err_d   = err_clr ? 1'b0 : timeout_err;

      case (state_q)
         IDLE: begin
            wb_ack = wb_req;
            if (wb_req) begin
               req_d   = '{src: wb_src, dst: wb_dst};
               cnt_clr = 1'b1;
               if (needs_unit(WAIT_MASK, wb_src)) begin
                  state_d = WAIT;
                  start_d = 1'b1;
               end else begin
                  state_d = WRITE;
                  write_d = (wb_dst != '0);
               end
            end
         end
         WAIT: begin
            cnt_en = 1'b1;
            // A completing unit beats a coincident timeout
            if (unit_done) begin
               state_d = WRITE;
               write_d = (req_q.dst != '0);
            end else if (cnt_tc_c) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign data_ctrl = req_q.src;
   assign reg_addr  = req_q.dst;

endmodule
